hpi_bus_sequencer: RTL and testbench

Avalon-MM slave that converts single 16-bit read/write requests into timed CY7C67200 HPI bus cycles. It drives the OTG controller's chip select, read/write strobes, register address and data bus, replacing the software bit-banged chip-select PIO. It sits between the Nios II data master and the top-level OTG_* pins, with a tri-state buffer at the top level driven by otg_data_oe.

---
 rtl/hpi_pkg.sv | 22 ++
 rtl/hpi_bus_sequencer.sv | 162 ++++++++++++++++
 tb/tb_hpi_bus_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_pkg.sv
// Shared definitions for the CY7C67200 HPI bus sequencer.
//   hpi_state_e : sequencer FSM states
//   HPI_*       : HPI register addresses as presented on otg_addr
//   HPI_CNT_W   : width of the per-phase cycle down-counter
package hpi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  localparam int unsigned HPI_CNT_W = 4;

endpackage

// File: rtl/hpi_bus_sequencer.sv
// Avalon-MM slave that turns single 16-bit read/write requests into timed
// CY7C67200 HPI bus cycles (setup, strobe, hold, recovery phases).
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address, read, write,
//   writedata, readdata,
//   waitrequest           Avalon-MM slave interface
//   otg_addr, otg_cs_n,
//   otg_rd_n, otg_wr_n    HPI control pins (all registered)
//   otg_data_out,
//   otg_data_oe           data to drive onto the HPI bus and its enable;
//                         the tri-state buffer lives at the top level
//   otg_data_in           HPI bus input, already synchronised
//   busy                  high whenever the sequencer is not idle
module hpi_bus_sequencer
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        busy
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("hpi_bus_sequencer: SETUP_CYC must be 1..15");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
    $error("hpi_bus_sequencer: STROBE_CYC must be 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("hpi_bus_sequencer: HOLD_CYC must be 1..15");
  end
  if (RECOVERY_CYC < 1 || RECOVERY_CYC > 15) begin : g_bad_recovery
    $error("hpi_bus_sequencer: RECOVERY_CYC must be 1..15");
  end

  localparam logic [HPI_CNT_W-1:0] SETUP_LD    = HPI_CNT_W'(SETUP_CYC - 1);
  localparam logic [HPI_CNT_W-1:0] STROBE_LD   = HPI_CNT_W'(STROBE_CYC - 1);
  localparam logic [HPI_CNT_W-1:0] HOLD_LD     = HPI_CNT_W'(HOLD_CYC - 1);
  localparam logic [HPI_CNT_W-1:0] RECOVERY_LD = HPI_CNT_W'(RECOVERY_CYC - 1);

  hpi_state_e           state_q;
  logic [HPI_CNT_W-1:0] cnt_q;
  logic                 dir_wr_q;
  logic                 ack_q;
  logic [15:0]          readdata_q;
  logic [1:0]           otg_addr_q;
  logic                 otg_cs_n_q;
  logic                 otg_rd_n_q;
  logic                 otg_wr_n_q;
  logic [15:0]          otg_data_out_q;
  logic                 otg_data_oe_q;

  // Every output is computed one cycle ahead and registered, so each phase's
  // pin values are loaded on the transition into that phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      dir_wr_q       <= 1'b0;
      ack_q          <= 1'b0;
      readdata_q     <= '0;
      otg_addr_q     <= '0;
      otg_cs_n_q     <= 1'b1;
      otg_rd_n_q     <= 1'b1;
      otg_wr_n_q     <= 1'b1;
      otg_data_out_q <= '0;
      otg_data_oe_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (read || write) begin
            dir_wr_q       <= write;  // write wins when both are requested
            otg_addr_q     <= address;
            otg_data_out_q <= writedata;
            otg_cs_n_q     <= 1'b0;
            otg_data_oe_q  <= write;
            cnt_q          <= SETUP_LD;
            state_q        <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            otg_rd_n_q <= dir_wr_q;
            otg_wr_n_q <= ~dir_wr_q;
            cnt_q      <= STROBE_LD;
            state_q    <= STROBE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            otg_rd_n_q <= 1'b1;
            otg_wr_n_q <= 1'b1;
            if (!dir_wr_q) begin
              readdata_q <= otg_data_in;
            end
            // A one-cycle hold phase is also the ack cycle.
            ack_q   <= (HOLD_CYC == 1);
            cnt_q   <= HOLD_LD;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            otg_cs_n_q    <= 1'b1;
            otg_data_oe_q <= 1'b0;
            cnt_q         <= RECOVERY_LD;
            state_q       <= RECOVER;
          end else begin
            ack_q <= (cnt_q == HPI_CNT_W'(1));
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RECOVER: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign waitrequest  = (read | write) & ~ack_q;
  assign busy         = (state_q != IDLE);
  assign readdata     = readdata_q;
  assign otg_addr     = otg_addr_q;
  assign otg_cs_n     = otg_cs_n_q;
  assign otg_rd_n     = otg_rd_n_q;
  assign otg_wr_n     = otg_wr_n_q;
  assign otg_data_out = otg_data_out_q;
  assign otg_data_oe  = otg_data_oe_q;

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Self-checking bench for hpi_bus_sequencer: one default-timing instance (A)
// and one instance with SETUP=3, STROBE=1, HOLD=2, RECOVERY=1 (B).
module tb_hpi_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        read, write;
  logic [15:0] writedata;
  logic [15:0] otg_data_in;
  logic        sel;

  logic        rd_a, wr_a, rd_b, wr_b;
  logic [15:0] readdata_a, readdata_b, dout_a, dout_b;
  logic [1:0]  oaddr_a, oaddr_b;
  logic        wait_a, wait_b, cs_a, cs_b, rdn_a, rdn_b, wrn_a, wrn_b;
  logic        oe_a, oe_b, busy_a, busy_b;

  logic [15:0] o_readdata, o_dout;
  logic [1:0]  o_addr;
  logic        o_wait, o_cs_n, o_rd_n, o_wr_n, o_oe, o_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_rd [2];

  always #5 clk = ~clk;

  assign rd_a = read  & ~sel;
  assign wr_a = write & ~sel;
  assign rd_b = read  &  sel;
  assign wr_b = write &  sel;

  assign o_readdata = sel ? readdata_b : readdata_a;
  assign o_dout     = sel ? dout_b     : dout_a;
  assign o_addr     = sel ? oaddr_b    : oaddr_a;
  assign o_wait     = sel ? wait_b     : wait_a;
  assign o_cs_n     = sel ? cs_b       : cs_a;
  assign o_rd_n     = sel ? rdn_b      : rdn_a;
  assign o_wr_n     = sel ? wrn_b      : wrn_a;
  assign o_oe       = sel ? oe_b       : oe_a;
  assign o_busy     = sel ? busy_b     : busy_a;

  hpi_bus_sequencer u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .read(rd_a), .write(wr_a),
    .writedata(writedata), .readdata(readdata_a), .waitrequest(wait_a),
    .otg_addr(oaddr_a), .otg_cs_n(cs_a), .otg_rd_n(rdn_a), .otg_wr_n(wrn_a),
    .otg_data_out(dout_a), .otg_data_oe(oe_a), .otg_data_in(otg_data_in),
    .busy(busy_a)
  );

  hpi_bus_sequencer #(
    .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVERY_CYC(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .read(rd_b), .write(wr_b),
    .writedata(writedata), .readdata(readdata_b), .waitrequest(wait_b),
    .otg_addr(oaddr_b), .otg_cs_n(cs_b), .otg_rd_n(rdn_b), .otg_wr_n(wrn_b),
    .otg_data_out(dout_b), .otg_data_oe(oe_b), .otg_data_in(otg_data_in),
    .busy(busy_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50; i++) begin
      if (!busy_a && !busy_b) break;
      @(negedge clk);
    end
    if (i == 50) check("idle_timeout", 16'd1, 16'd0);
  endtask

  // Reference model: cycle 0 is the cycle the idle sequencer sees the
  // request; the expected pin values for cycle k follow from the phase
  // lengths alone.
  task automatic run_txn(input logic s_dut, input logic do_wr, input logic do_rd,
                         input logic [1:0] a, input logic [15:0] wd,
                         input logic [15:0] din);
    int s, t, h, r, last, total;
    logic is_w, cs_low, strb, ack, busy_e, req;
    if (s_dut) begin s = 3; t = 1; h = 2; r = 1; end
    else       begin s = 1; t = 4; h = 1; r = 2; end
    last  = s + t + h;
    total = last + r;
    is_w  = do_wr;
    @(negedge clk);
    sel = s_dut; address = a; writedata = wd;
    read = do_rd; write = do_wr;
    otg_data_in = din ^ 16'h5A5A;
    #1;
    check("c0_wait", 16'(o_wait), 16'd1);
    check("c0_cs_n", 16'(o_cs_n), 16'd1);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      if (k == s + t)     otg_data_in = din;
      if (k == s + t + 1) otg_data_in = ~din;
      #1;
      req    = (k <= last);
      cs_low = (k >= 1) && (k <= last);
      strb   = (k >= s + 1) && (k <= s + t);
      ack    = (k == last);
      busy_e = (k >= 1) && (k <= total);
      if (!is_w && k == s + t + 1) exp_rd[s_dut] = din;
      check($sformatf("cs_n k=%0d", k), 16'(o_cs_n), 16'(!cs_low));
      check($sformatf("rd_n k=%0d", k), 16'(o_rd_n), 16'(!(strb && !is_w)));
      check($sformatf("wr_n k=%0d", k), 16'(o_wr_n), 16'(!(strb && is_w)));
      check($sformatf("oe k=%0d", k),   16'(o_oe),   16'(cs_low && is_w));
      check($sformatf("busy k=%0d", k), 16'(o_busy), 16'(busy_e));
      check($sformatf("wait k=%0d", k), 16'(o_wait), 16'(req && !ack));
      check($sformatf("readdata k=%0d", k), o_readdata, exp_rd[s_dut]);
      if (cs_low) check($sformatf("addr k=%0d", k), 16'(o_addr), 16'(a));
      if (cs_low && is_w) check($sformatf("dout k=%0d", k), o_dout, wd);
      if (ack) begin read = 1'b0; write = 1'b0; end
    end
  endtask

  initial begin
    int fall [$];
    int hi_cnt, ack1, ack2, f0, f1;
    logic prev_cs, phase, sw_pending;
    logic [15:0] rd_bb;

    reset_n = 1'b0; sel = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; otg_data_in = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", 16'(cs_a), 16'd1);
    check("rst_rd_n", 16'(rdn_a), 16'd1);
    check("rst_wr_n", 16'(wrn_a), 16'd1);
    check("rst_oe", 16'(oe_a), 16'd0);
    check("rst_addr", 16'(oaddr_a), 16'd0);
    check("rst_dout", dout_a, 16'd0);
    check("rst_readdata", readdata_a, 16'd0);
    check("rst_busy", 16'(busy_a), 16'd0);
    check("rst_busy_b", 16'(busy_b), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed write, read, simultaneous request
    run_txn(1'b0, 1'b1, 1'b0, 2'd2, 16'h1234, 16'h0000);
    run_txn(1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 16'hBEEF);
    run_txn(1'b0, 1'b1, 1'b1, 2'd1, 16'h00A5, 16'h9999);
    check("rd_retained", readdata_a, 16'hBEEF);

    // Back-to-back: write, then read presented right after the write ack
    @(negedge clk);
    sel = 1'b0; address = 2'd2; writedata = 16'hC3C3; write = 1'b1; read = 1'b0;
    rd_bb = 16'h7E81; otg_data_in = rd_bb;
    prev_cs = 1'b1; phase = 1'b0; sw_pending = 1'b0;
    hi_cnt = 0; ack1 = -1; ack2 = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (sw_pending) begin
        write = 1'b0; read = 1'b1; address = 2'd0; phase = 1'b1; sw_pending = 1'b0;
      end
      #1;
      if (prev_cs && !o_cs_n) fall.push_back(cyc);
      if (fall.size() == 1 && o_cs_n) hi_cnt++;
      prev_cs = o_cs_n;
      if (!phase && !o_wait) begin ack1 = cyc; sw_pending = 1'b1; end
      else if (phase && !o_wait) begin
        ack2 = cyc;
        check("b2b_readdata", o_readdata, rd_bb);
        read = 1'b0;
        break;
      end
    end
    exp_rd[0] = rd_bb;
    f0 = (fall.size() > 0) ? fall[0] : -1;
    f1 = (fall.size() > 1) ? fall[1] : -1;
    check("b2b_fall0", 16'(f0), 16'd1);
    check("b2b_gap", 16'(f1 - f0), 16'd9);
    check("b2b_ack1", 16'(ack1), 16'd6);
    check("b2b_ack2", 16'(ack2), 16'd15);
    // recovery cycles plus the idle cycle in which the read is accepted
    check("b2b_cs_high", 16'(hi_cnt), 16'd3);
    wait_idle();

    // Parameter sweep instance
    run_txn(1'b1, 1'b1, 1'b0, 2'd3, 16'hA55A, 16'h0000);
    run_txn(1'b1, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h4C2D);

    // Randomized transactions on both instances
    for (int i = 0; i < 16; i++) begin
      logic s_r, w_r, r_r;
      s_r = (i >= 11);
      w_r = 1'($urandom_range(0, 1));
      r_r = 1'($urandom_range(0, 1));
      if (!w_r && !r_r) r_r = 1'b1;
      run_txn(s_r, w_r, r_r, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    end

    // Reset in the middle of a write strobe
    @(negedge clk);
    sel = 1'b0; address = 2'd2; writedata = 16'h1357; write = 1'b1; read = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_wr_n", 16'(wrn_a), 16'd0);
    reset_n = 1'b0;
    #1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    check("midrst_wr_n", 16'(wrn_a), 16'd1);
    check("midrst_cs_n", 16'(cs_a), 16'd1);
    check("midrst_oe", 16'(oe_a), 16'd0);
    check("midrst_busy", 16'(busy_a), 16'd0);
    check("midrst_wait", 16'(wait_a), 16'd1);
    check("midrst_readdata", readdata_a, 16'd0);
    @(negedge clk);
    write = 1'b0;
    #1;
    check("midrst_wait_drop", 16'(wait_a), 16'd0);
    reset_n = 1'b1;
    run_txn(1'b0, 1'b0, 1'b1, 2'd3, 16'h0000, 16'h6AD1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
